// File: rtl/ex_operand_stage.sv
// ID/EX register and operand select: latches ID fields, forwards EX/MEM then MEM/WB per operand.
// Latency 1 cycle; stall holds the stage (capturing live forwards), flush inserts a zero bubble.
module ex_operand_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int OP_W       = 3,
    parameter int IMM_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [OP_W-1:0]       id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic                  id_use_imm,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [OP_W-1:0]       ALUOp,
    output logic [DATA_W-1:0]     Operand1,
    output logic [DATA_W-1:0]     Operand2,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write
);

    logic                  valid_q,     valid_d;
    logic [OP_W-1:0]       alu_op_q,    alu_op_d;
    logic [REG_ADDR_W-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_ADDR_W-1:0] rt_addr_q,   rt_addr_d;
    logic [DATA_W-1:0]     rs_data_q,   rs_data_d;
    logic [DATA_W-1:0]     rt_data_q,   rt_data_d;
    logic [IMM_W-1:0]      imm_q,       imm_d;
    logic                  use_imm_q,   use_imm_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic                  reg_write_q, reg_write_d;

    logic                  exmem_hit_rs, exmem_hit_rt, memwb_hit_rs, memwb_hit_rt;
    logic [DATA_W-1:0]     rs_fwd, rt_fwd, imm_ext;

    // Register 0 is hardwired zero, so it never matches a forwarding source.
    assign exmem_hit_rs = exmem_reg_write && (exmem_rd_addr == rs_addr_q) && (rs_addr_q != '0);
    assign exmem_hit_rt = exmem_reg_write && (exmem_rd_addr == rt_addr_q) && (rt_addr_q != '0);
    assign memwb_hit_rs = memwb_reg_write && (memwb_rd_addr == rs_addr_q) && (rs_addr_q != '0);
    assign memwb_hit_rt = memwb_reg_write && (memwb_rd_addr == rt_addr_q) && (rt_addr_q != '0);

    always_comb begin
        rs_fwd = rs_data_q;
        if (exmem_hit_rs)      rs_fwd = exmem_result;
        else if (memwb_hit_rs) rs_fwd = memwb_result;
        rt_fwd = rt_data_q;
        if (exmem_hit_rt)      rt_fwd = exmem_result;
        else if (memwb_hit_rt) rt_fwd = memwb_result;
    end

    assign imm_ext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            alu_op_d    = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            rd_addr_d   = '0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            // Capture forwarded data so it survives the producer retiring during the stall.
            rs_data_d = rs_fwd;
            rt_data_d = rt_fwd;
        end else begin
            valid_d     = id_valid;
            alu_op_d    = id_alu_op;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_reg_write & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign ALUOp         = alu_op_q;
    assign Operand1      = rs_fwd;
    assign Operand2      = use_imm_q ? imm_ext : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = valid_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized scoreboard bench for ex_operand_stage against a behavioural stage model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        id_valid = 1'b0, id_use_imm = 1'b0, id_reg_write = 1'b0;
    logic [2:0]  id_alu_op = '0, id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
    logic [15:0] id_rs_data = '0, id_rt_data = '0;
    logic [5:0]  id_imm = '0;
    logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
    logic [2:0]  exmem_rd_addr = '0, memwb_rd_addr = '0;
    logic [15:0] exmem_result = '0, memwb_result = '0;
    logic [2:0]  ALUOp, ex_rd_addr;
    logic [15:0] Operand1, Operand2, ex_store_data;
    logic        ex_valid, ex_reg_write;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .ALUOp(ALUOp), .Operand1(Operand1), .Operand2(Operand2), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [2:0]  op, rsa, rta, rd;
        logic [15:0] rsd, rtd;
        logic [5:0]  imm;
        logic        ui, rw;
    } inst_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] o1, o2, sd;
        logic        v;
        logic [2:0]  rd;
        logic        rw;
    } exp_t;

    inst_t st;
    exp_t  sb_q[$];
    int    checks = 0;
    int    failures = 0;

    // Value a source register reads as, given the writers currently in flight.
    function automatic logic [15:0] reg_value(input logic [2:0] a, input logic [15:0] stored);
        if (a == 0) return stored;
        if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
        return stored;
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        int s;
        s = (v >= 32) ? int'(v) - 64 : int'(v);
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Called just after a falling edge once inputs are set; ends at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (!rst_n) st = '0;
        e.op = st.op;
        e.o1 = reg_value(st.rsa, st.rsd);
        e.sd = reg_value(st.rta, st.rtd);
        e.o2 = st.ui ? sext6(st.imm) : e.sd;
        e.v  = st.v;
        e.rd = st.rd;
        e.rw = st.rw;
        sb_q.push_back(e);
        if (rst_n) begin
            if (flush) st = '0;
            else if (stall) begin
                st.rsd = reg_value(st.rsa, st.rsd);
                st.rtd = reg_value(st.rta, st.rtd);
            end else begin
                st.v = id_valid; st.op = id_alu_op; st.rsa = id_rs_addr; st.rta = id_rt_addr;
                st.rsd = id_rs_data; st.rtd = id_rt_data; st.imm = id_imm; st.ui = id_use_imm;
                st.rd = id_rd_addr; st.rw = id_reg_write & id_valid;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [2:0] op, input logic [2:0] rsa, input logic [15:0] rsd,
                          input logic [2:0] rta, input logic [15:0] rtd, input logic [5:0] imm,
                          input logic ui, input logic [2:0] rd, input logic rw);
        id_valid = v; id_alu_op = op; id_rs_addr = rsa; id_rs_data = rsd; id_rt_addr = rta;
        id_rt_data = rtd; id_imm = imm; id_use_imm = ui; id_rd_addr = rd; id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [2:0] ea, input logic [15:0] er,
                           input logic mw, input logic [2:0] ma, input logic [15:0] mr);
        exmem_reg_write = ew; exmem_rd_addr = ea; exmem_result = er;
        memwb_reg_write = mw; memwb_rd_addr = ma; memwb_result = mr;
    endtask

    // Monitor: the stage presents a result every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ALUOp",         16'(ALUOp),        16'(e.op));
                chk("Operand1",      Operand1,          e.o1);
                chk("Operand2",      Operand2,          e.o2);
                chk("ex_store_data", ex_store_data,     e.sd);
                chk("ex_valid",      16'(ex_valid),     16'(e.v));
                chk("ex_rd_addr",    16'(ex_rd_addr),   16'(e.rd));
                chk("ex_reg_write",  16'(ex_reg_write), 16'(e.rw));
            end
        end
    end

    initial begin
        logic [2:0] a, b;
        st = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        set_id(1, 3'b010, 3'd1, 16'd30, 3'd2, 16'd3, 6'd0, 0, 3'd4, 1);
        tick();
        set_id(1, 3'b001, 3'd5, 16'd10, 3'd6, 16'd55, 6'b111100, 1, 3'd5, 1);
        tick();
        set_id(1, 3'b011, 3'd2, 16'd1, 3'd0, 16'd0, 6'd0, 0, 3'd1, 1);
        tick();
        set_fwd(1, 3'd2, -16'sd10, 1, 3'd2, 16'd7);
        stall = 1;
        tick();
        exmem_reg_write = 0;
        tick();
        stall = 0;
        set_id(1, 3'b100, 3'd0, 16'd0, 3'd3, 16'd100, 6'd0, 0, 3'd2, 0);
        set_fwd(1, 3'd0, 16'h1234, 1, 3'd0, 16'h5678);
        tick();
        set_fwd(0, 3'd0, 16'd0, 1, 3'd3, -16'sd9);
        stall = 1;
        tick();
        tick();
        memwb_reg_write = 0;
        tick();
        stall = 0;
        set_id(1, 3'b110, 3'd1, 16'hFFFF, 3'd3, 16'd42, 6'd5, 0, 3'd7, 1);
        tick();
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        tick();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            set_id(1'($urandom), 3'($urandom), a, (a == 0) ? 16'd0 : 16'($urandom),
                   b, (b == 0) ? 16'd0 : 16'($urandom), 6'($urandom), 1'($urandom),
                   3'($urandom), 1'($urandom));
            set_fwd(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
        end
        #3;
        chk("scoreboard_drain", 16'(sb_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage of the 16-bit pipelined processor; sits directly upstream of the ALU.
- Latches decoded instruction fields from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's ALUOp, Operand1 and Operand2 inputs.
- Honours stall and flush from the hazard unit.

Parameters:
- DATA_W, 16, datapath width (ALU operand width)
- REG_ADDR_W, 3, register address width; register 0 is hardwired zero
- OP_W, 3, ALU opcode width
- IMM_W, 6, immediate field width, sign-extended to DATA_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  insert bubble
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  OP_W  ALU opcode
- id_rs_addr, id_rt_addr  in  REG_ADDR_W  source register addresses
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  IMM_W  immediate
- id_use_imm  in  1  Operand2 selects immediate
- id_rd_addr  in  REG_ADDR_W  destination register
- id_reg_write  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd_addr  in  REG_ADDR_W  EX/MEM destination
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd_addr  in  REG_ADDR_W  MEM/WB destination
- memwb_result  in  DATA_W  MEM/WB writeback value
- ALUOp  out  OP_W  to ALU
- Operand1, Operand2  out  DATA_W  signed operands to ALU
- ex_store_data  out  DATA_W  forwarded rt value, for stores
- ex_valid  out  1  EX holds a real instruction
- ex_rd_addr  out  REG_ADDR_W  destination, passed down
- ex_reg_write  out  1  write enable, gated by ex_valid

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers clear to 0. Outputs read ALUOp=0, Operand1=0, Operand2=0, ex_store_data=0, ex_valid=0, ex_rd_addr=0, ex_reg_write=0.
- Normal operation (no stall, no flush): on the rising edge, latch all id_* fields. Stored reg_write = id_reg_write AND id_valid. Latency is 1 cycle from ID to ALU inputs.
- Flush: flush has priority over stall. On the edge, all stage registers clear to 0, giving a bubble with the reset values.
- Stall without flush: stage registers hold.
  - Exception: if a forward hit applies to rs or rt this cycle, the stored rs_data/rt_data is overwritten with the forwarded value.
  - This keeps the value alive after the producer leaves MEM/WB. The stored address is unchanged.
- Forwarding is combinational on the stored rs/rt, evaluated per operand:
  - EX/MEM hit: exmem_reg_write=1 and exmem_rd_addr equals the stored address and the address is nonzero. Use exmem_result.
  - Otherwise MEM/WB hit: same rule with memwb_*. Use memwb_result.
  - Otherwise use the stored register-file data.
  - When both stages match, EX/MEM wins.
  - Address 0 never forwards; it always yields the stored data, which ID supplies as 0.
- Operand outputs:
  - Operand1 = forwarded rs.
  - Operand2 = sign-extended stored imm if the stored use_imm is 1, else forwarded rt.
  - ex_store_data = forwarded rt, regardless of use_imm.
- Sign extension: bit IMM_W-1 is replicated. Example: imm 6'b111100 gives 16'hFFFC (-4).
- The hazard unit never asserts a load-use stall and flush in conflict. Flush simply wins.
- Reset mid-stall or mid-flush: asynchronous clear wins immediately. The first edge after rst_n rises behaves as normal operation.

Test Plan:
- Reset then release: all outputs 0. Load id_alu_op=3'b010, rs_data=30, rt_data=3, use_imm=0, no forward hits -> next cycle ALUOp=010, Operand1=30, Operand2=3, ex_valid=1.
- Immediate path: id_use_imm=1, id_imm=6'b111100, rs_data=10 -> Operand1=10, Operand2=-4 (16'hFFFC). ex_store_data = latched rt_data.
- Forward priority: stored rs=r2; exmem writes r2=-10 and memwb writes r2=7 -> Operand1=-10. Drop exmem_reg_write -> Operand1=7. Set rs=r0 with both writing r0 -> Operand1=0.
- Stall capture: stall=1 with memwb writing r3=-9 and stored rt=r3. Next cycle memwb_reg_write=0, stall still 1 -> Operand2 stays -9. Release stall -> new ID fields latch.
- Flush over stall: stall=1 and flush=1 with valid instruction held -> next cycle ex_valid=0, ex_reg_write=0, Operand1=Operand2=0, ALUOp=0.
- Asynchronous reset mid-operation: assert rst_n low between clock edges while ex_valid=1, Operand1=-1 -> outputs clear to 0 immediately, before the next edge.
